// File: rtl/unpacked_deserializer.sv
// Serial-to-parallel deserializer: collects M single-bit elements into an
// unpacked store and presents them as a packed word under valid/ready.
module unpacked_deserializer #(
  parameter int unsigned M = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  input  logic         in_bit,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_word,
  output logic         out_elems [M]
);

  localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mem [M];
  logic          accept;

  // A held word frees the input only in the cycle it is being consumed.
  assign in_ready  = !reset && !clear && ((state == FILL) || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);
  assign out_elems = mem;

  always_comb begin
    out_word = '0;
    for (int i = 0; i < int'(M); i++) out_word[i] = mem[i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
      cnt   <= '0;
      for (int i = 0; i < int'(M); i++) mem[i] <= 1'b0;
    end else if (clear) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            mem[cnt] <= in_bit;
            if (cnt == CW'(M - 1)) begin
              state <= HOLD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= FILL;
            // Back-to-back: the bit arriving with the handoff starts the next word.
            if (in_valid) begin
              mem[0] <= in_bit;
              cnt    <= CW'(1);
            end else begin
              cnt <= '0;
            end
          end
        end
        default: begin
          state <= FILL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/unpacked_deserializer.md
UNPACKED_DESERIALIZER -- requirements
Module: unpacked_deserializer

Interface
REQ-001 The block SHALL have parameter M, default 2, giving the number of word elements; legal range 2..64.
REQ-002 Port clock, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-004 Port clear, input, 1 bit, SHALL request a synchronous discard of any partial or held word.
REQ-005 Port in_valid, input, 1 bit, SHALL qualify in_bit.
REQ-006 Port in_bit, input, 1 bit, SHALL be the serial data element.
REQ-007 Port in_ready, output, 1 bit, SHALL indicate that in_bit is accepted this cycle when in_valid is high.
REQ-008 Port out_valid, output, 1 bit, SHALL indicate a complete word on out_word.
REQ-009 Port out_ready, input, 1 bit, SHALL indicate that the consumer takes the word this cycle.
REQ-010 Port out_word, output, M bits [M-1:0], SHALL be the packed word, with bit i equal to element i.
REQ-011 Port out_elems, output, unpacked array of M single bits, declared by size [M], SHALL carry the same word, with element i equal to out_word[i].

Function
REQ-012 Storage SHALL be an unpacked array of M bits, declared by size; it SHALL also be used as the value behind out_word and out_elems, with no separate register copy.
REQ-013 The state machine SHALL have exactly two states: FILL and HOLD.
REQ-014 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-015 In FILL, an accepted bit (in_valid=1) SHALL be written to the element at index cnt, and cnt SHALL increment.
- cnt is ceil(log2(M)) bits wide, ranging 0..M-1.
- Element 0 is the first bit received.
REQ-016 An accept in FILL with cnt=M-1 SHALL set the state to HOLD and wrap cnt to 0 on the next edge.
- out_valid rises in the cycle after the final bit is accepted (latency is 1 cycle from the last accept).
REQ-017 In HOLD, out_valid SHALL be 1 and the storage SHALL be stable until the word is consumed.
REQ-018 In HOLD with out_ready=0, in_ready SHALL be 0 and in_bit SHALL be ignored.
REQ-019 In HOLD with out_ready=1, in_ready SHALL be 1 (combinational pass-through of out_ready).
- If in_valid=1 in the same cycle, the bit SHALL be written to element 0, cnt becomes 1, and the state returns to FILL.
- Result: no bubble, and one bit per cycle of sustained throughput.
REQ-020 Elements not yet rewritten during a new FILL SHALL keep their old values; consumers SHALL use out_word only while out_valid=1.
REQ-021 clear=1 SHALL, on the next edge, set the state to FILL and cnt to 0, and SHALL discard any bit presented in that cycle.
- in_ready SHALL be 0 while clear=1.
- out_valid SHALL drop on the next edge even if out_ready=0.
REQ-022 reset SHALL take priority over clear, and clear SHALL take priority over all handshake events.
REQ-023 out_valid SHALL NOT drop without out_ready=1, except through clear or reset.
REQ-024 out_word and out_elems SHALL NOT change while out_valid=1 and out_ready=0.

Reset
REQ-025 While reset=1 at a rising edge, the following SHALL occur:
- state becomes FILL and cnt becomes 0;
- every storage element becomes 0;
- out_valid becomes 0 and in_ready becomes 0.
REQ-026 In the first cycle after reset is released, in_ready SHALL be 1, out_valid 0 and out_word all zeros.
REQ-027 Reset asserted mid-word or in HOLD SHALL discard the word with no out_valid pulse.

Verification (M=4 unless stated)
REQ-028 Scenario: reset, then bits 1,0,1,1 on 4 consecutive in_valid cycles with out_ready=0 -> out_valid=1 from the cycle after the 4th accept, out_word=4'b1101, out_elems='{1,0,1,1} by index 0..3, in_ready=0.
REQ-029 Scenario: hold the word for 5 cycles with out_ready=0 while in_valid toggles -> out_word stays 4'b1101 and no bit is accepted; then out_ready=1 with in_valid=1, in_bit=0 -> out_valid falls and cnt=1 with element0=0.
REQ-030 Scenario: continuous in_valid and out_ready=1 for 12 cycles with pattern 1010 repeated -> out_valid pulses for exactly 1 cycle every 4 cycles, each with out_word=4'b0101, and in_ready never falls.
REQ-031 Scenario: 2 bits accepted, then clear=1 with in_valid=1 -> bit not accepted, cnt=0; the next 4 bits 0,0,1,0 give out_word=4'b0100.
REQ-032 Scenario: in HOLD, reset=1 and clear=1 together -> out_valid=0, out_word=0, in_ready=0 during reset, and in_ready=1 in the cycle after release.
REQ-033 Scenario: M=2 default, bits 1,1 -> out_word=2'b11; then out_ready=1 and in_valid=0 -> out_valid=0 and state FILL.
